// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory lane controller: RV32I width codes,
// controller states and the access-size decode.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RESP
  } state_e;

  // Access size in bytes (1/2/4). 0 flags an illegal request, including unsigned stores.
  function automatic logic [2:0] size_decode(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B:    return 3'd1;
      F3_H:    return 3'd2;
      F3_W:    return 3'd4;
      F3_BU:   return we ? 3'd0 : 3'd1;
      F3_HU:   return we ? 3'd0 : 3'd2;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl_if.sv
// CPU-side request/response channel of the data-memory lane controller.
interface dmem_lane_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_map.sv
// Byte-lane steering: maps the low address bits and access size onto per-lane
// write masks, rotated store bytes, word increments and the gathered load word.
module dmem_lane_map (
  input  logic [1:0]  a_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] lane_q,
  output logic [3:0]  wrd_inc,
  output logic [3:0]  we_mask,
  output logic [31:0] lane_d,
  output logic [31:0] raw
);

  // NOTE: every output gets a default before the loops so no path leaves one unassigned (no latch).
  always_comb begin
    wrd_inc = '0;
    we_mask = '0;
    lane_d  = '0;
    raw     = '0;
    for (int i = 0; i < 4; i++) begin
      // Lane i holds byte k = (i - a_lo) mod 4; lanes below a_lo fall in the next word.
      wrd_inc[i]       = 2'(i) < a_lo;
      we_mask[i]       = {1'b0, 2'(i) - a_lo} < size;
      lane_d[8*i +: 8] = wdata[{2'(i) - a_lo, 3'b000} +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = lane_q[{2'(k) + a_lo, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// Data-memory front end: zero-fills the four byte-lane RAMs after reset, then turns
// RV32I load/store requests into lane accesses with a registered, extended response.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_lane_ctrl_if.slave       bus,
  output logic [4*ADDR_W-1:0]   lane_addr,
  output logic [31:0]           lane_d,
  output logic [3:0]            lane_we,
  input  logic [31:0]           lane_q
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [ADDR_W+1:0]   a;
  logic [ADDR_W-1:0]   word_base;
  logic [2:0]          size;
  logic                req_err;
  logic                req_ready;
  logic [3:0]          wrd_inc, we_mask;
  logic [31:0]         map_d, raw;
  logic [31:0]         ext_data;
  logic                unused_addr_hi;

  assign a              = bus.req_addr[ADDR_W+1:0];
  assign word_base      = a[ADDR_W+1:2];
  assign size           = size_decode(bus.req_funct3, bus.req_we);
  assign req_err        = (size == 3'd0);
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  dmem_lane_map u_map (
    .a_lo    (a[1:0]),
    .size    (size),
    .wdata   (bus.req_wdata),
    .lane_q  (lane_q),
    .wrd_inc (wrd_inc),
    .we_mask (we_mask),
    .lane_d  (map_d),
    .raw     (raw)
  );

  always_comb begin
    case (bus.req_funct3)
      F3_B:    ext_data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext_data = {{16{raw[15]}}, raw[15:0]};
      F3_W:    ext_data = raw;
      F3_BU:   ext_data = {24'd0, raw[7:0]};
      F3_HU:   ext_data = {16'd0, raw[15:0]};
      default: ext_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    lane_we     = '0;
    lane_d      = map_d;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i*ADDR_W +: ADDR_W] = word_base + ADDR_W'(wrd_inc[i]);
    end

    case (state_q)
      ST_CLEAR: begin
        lane_addr = {4{clr_cnt_q}};
        lane_d    = '0;
        lane_we   = 4'hF;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bus.req_we && !req_err) lane_we = we_mask;
          rsp_err_d   = req_err;
          rsp_rdata_d = (req_err || bus.req_we) ? 32'd0 : ext_data;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Scoreboard bench for dmem_lane_ctrl: four behavioural byte-lane RAMs, directed
// load/store vectors with hand-computed results, and a decoupled response monitor.
module tb_dmem_lane_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [4*ADDR_W-1:0] lane_addr;
  logic [31:0]         lane_d;
  logic [3:0]          lane_we;
  logic [31:0]         lane_q;
  logic [7:0]          mem [4][DEPTH];

  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t exp_q[$];

  dmem_lane_ctrl_if bus ();

  dmem_lane_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lane_addr (lane_addr),
    .lane_d    (lane_d),
    .lane_we   (lane_we),
    .lane_q    (lane_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (lane_we[i]) mem[i][lane_addr[i*ADDR_W +: ADDR_W]] <= lane_d[8*i +: 8];
  end

  always_comb begin
    lane_q = '0;
    for (int i = 0; i < 4; i++) lane_q[8*i +: 8] = mem[i][lane_addr[i*ADDR_W +: ADDR_W]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(bus.rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  // Issue one request; lane outputs are checked in the accept cycle when chk_lane is set.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [3:0] exp_we, input bit chk_lane,
                        input logic [4*ADDR_W-1:0] exp_addr, input logic [31:0] exp_d);
    int n = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_wait", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    check("lane_we", 64'(lane_we), 64'(exp_we));
    if (chk_lane) begin
      check("lane_addr", 64'(lane_addr), 64'(exp_addr));
      check("lane_d", 64'(lane_d), 64'(exp_d));
    end
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rsp_latency", 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'd0, exp, 1'b0, 4'h0, 1'b0, '0, '0);
  endtask

  task automatic clear_sequence();
    bit bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lane_we !== 4'hF || lane_d !== 32'd0 || bus.req_ready !== 1'b0 ||
          lane_addr !== {4{10'(i)}}) bad = 1;
      @(negedge clk);
    end
    check("clear_sequence", 64'(bad), 64'd0);
    check("ready_after_clear", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] held;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    for (int w = 0; w < DEPTH; w++)
      for (int l = 0; l < 4; l++) mem[l][w] = 8'hA5;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    clear_sequence();
    load(3'd2, 32'h3FC, 32'h0);

    do_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 4'hF, 1'b1,
           {10'd4, 10'd4, 10'd4, 10'd4}, 32'hDEADBEEF);
    load(3'd2, 32'h010, 32'hDEADBEEF);
    load(3'd0, 32'h013, 32'hFFFFFFDE);
    load(3'd4, 32'h013, 32'h000000DE);
    load(3'd1, 32'h012, 32'hFFFFDEAD);
    load(3'd5, 32'h010, 32'h0000BEEF);

    do_req(1'b1, 3'd2, 32'h011, 32'h11223344, 32'h0, 1'b0, 4'hF, 1'b1,
           {10'd4, 10'd4, 10'd4, 10'd5}, 32'h22334411);
    load(3'd2, 32'h011, 32'h11223344);
    load(3'd2, 32'h010, 32'h223344EF);

    do_req(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000A55A, 32'h0, 1'b0, 4'b1001, 1'b1,
           {10'd1023, 10'd0, 10'd0, 10'd0}, 32'h5A0000A5);
    load(3'd5, 32'h0FFF, 32'h0000A55A);
    load(3'd1, 32'h0FFF, 32'hFFFFA55A);

    do_req(1'b0, 3'd3, 32'h010, 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, '0, '0);
    do_req(1'b1, 3'd4, 32'h010, 32'hFFFFFFFF, 32'h0, 1'b1, 4'h0, 1'b0, '0, '0);
    load(3'd2, 32'h010, 32'h223344EF);

    // Stall: response held three cycles, a store presented meanwhile must have no effect.
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    load(3'd2, 32'h014, 32'h00000011);
    held = bus.rsp_rdata;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h014;
    bus.req_wdata  = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("stall_rsp_rdata", 64'(bus.rsp_rdata), 64'(held));
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      check("stall_lane_we", 64'(lane_we), 64'd0);
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    load(3'd2, 32'h014, 32'h00000011);

    // Reset while a response is pending drops it and restarts the clear.
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    load(3'd2, 32'h010, 32'h223344EF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_clear_addr", 64'(lane_addr), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    clear_sequence();
    load(3'd2, 32'h010, 32'h0);
    load(3'd5, 32'h0FFF, 32'h0);

    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
